// File: rtl/blk_lum_grid.sv
// Per-block luminance classifier for an HBLKS x VBLKS block grid.
// Weighted luma of each active pixel is summed per block segment (seg) and folded into a
// per-column accumulator on every block-segment close. At each block-row close, every
// column is compared against a runtime threshold with hysteresis around the block's
// previous-frame decision, and one decision bit per block is stored. The previous-frame
// decision of the block being scanned streams out on rx_o. A bright-block count is
// published once per frame.
// Ports:
//   clk_i, rst_i   pixel clock, synchronous active-high reset
//   de_i           pixel valid
//   h_save_i       last pixel of a block segment within a line
//   v_save_i       last pixel of the last line of a block row
//   wd_i           {R,G,B} pixel, R in MSBs
//   thres_i        mean-luma threshold (colour units)
//   hyst_i         hysteresis half-band (colour units)
//   en_i           0 forces rx_o low
//   rx_o           previous-frame decision of the current block
//   frame_done_o   1-cycle pulse after the last block row is classified
//   bright_cnt_o   bright-block count of the last completed frame
module blk_lum_grid #(
  parameter int unsigned HBLKS = 10,
  parameter int unsigned VBLKS = 10,
  parameter int unsigned PXS   = 900,
  parameter int unsigned CW    = 8,
  parameter int unsigned KR    = 109,
  parameter int unsigned KG    = 366,
  parameter int unsigned KB    = 37
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                de_i,
  input  logic                                h_save_i,
  input  logic                                v_save_i,
  input  logic [3*CW-1:0]                     wd_i,
  input  logic [CW-1:0]                       thres_i,
  input  logic [CW-1:0]                       hyst_i,
  input  logic                                en_i,
  output logic                                rx_o,
  output logic                                frame_done_o,
  output logic [$clog2(HBLKS*VBLKS+1)-1:0]    bright_cnt_o
);

  localparam longint unsigned CMax  = (64'd1 << CW) - 64'd1;
  localparam longint unsigned Scale = 64'(PXS) * 64'(KR + KG + KB);
  localparam longint unsigned MaxV  = Scale * CMax;
  localparam int unsigned     AccW  = $clog2(MaxV + 64'd1);
  localparam int unsigned     ColW  = $clog2(HBLKS);
  localparam int unsigned     RowW  = $clog2(VBLKS);
  localparam int unsigned     CntW  = $clog2(HBLKS * VBLKS + 1);

  function automatic logic [AccW-1:0] sat_add(input logic [AccW-1:0] a, input logic [AccW-1:0] b);
    logic [AccW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[AccW] ? '1 : s[AccW-1:0];
  endfunction

  function automatic logic [ColW-1:0] col_inc(input logic [ColW-1:0] c);
    return (c == ColW'(HBLKS - 1)) ? '0 : c + 1'b1;
  endfunction

  function automatic logic [RowW-1:0] row_inc(input logic [RowW-1:0] r);
    return (r == RowW'(VBLKS - 1)) ? '0 : r + 1'b1;
  endfunction

  logic [AccW-1:0]  y_d, y_q, seg_d, seg_q;
  logic             de_q;
  logic [1:0]       h_q, v_q;
  logic [AccW-1:0]  acc_d [HBLKS];
  logic [AccW-1:0]  acc_q [HBLKS];
  logic [HBLKS-1:0] store_d [VBLKS];
  logic [HBLKS-1:0] store_q [VBLKS];
  logic [ColW-1:0]  col_d, col_q, rcol_d, rcol_q;
  logic [RowW-1:0]  row_d, row_q, rrow_d, rrow_q;
  logic             eval_d, eval_q, fdp_d, fdp_q, frame_done_d, frame_done_q, rx_d, rx_q;
  logic [CntW-1:0]  cnt_d, cnt_q, pop;
  logic [CW:0]      th_sum;
  logic [CW-1:0]    hi_c, lo_c;
  logic [AccW-1:0]  t_hi, t_lo;
  logic             close;

  // Stage 1: weighted luma
  always_comb begin
    y_d = AccW'(KR) * AccW'(wd_i[3*CW-1 -: CW])
        + AccW'(KG) * AccW'(wd_i[2*CW-1 -: CW])
        + AccW'(KB) * AccW'(wd_i[CW-1:0]);
  end

  // Clamped thresholds, scaled to block-sum units
  always_comb begin
    th_sum = {1'b0, thres_i} + {1'b0, hyst_i};
    hi_c   = th_sum[CW] ? '1 : th_sum[CW-1:0];
    lo_c   = (thres_i > hyst_i) ? thres_i - hyst_i : '0;
    t_hi   = AccW'(Scale) * AccW'(hi_c);
    t_lo   = AccW'(Scale) * AccW'(lo_c);
  end

  assign close = h_q[1] | v_q[1];

  always_comb begin
    seg_d   = seg_q;
    acc_d   = acc_q;
    store_d = store_q;
    col_d   = col_q;
    row_d   = row_q;
    eval_d  = v_q[1];
    fdp_d   = 1'b0;

    if (close) begin
      // Pixel arriving on the close cycle starts the next segment
      seg_d = de_q ? y_q : '0;
    end else if (de_q) begin
      seg_d = sat_add(seg_q, y_q);
    end

    if (eval_q) begin
      for (int c = 0; c < HBLKS; c++) begin
        store_d[row_q][c] = store_q[row_q][c] ? (acc_q[c] >= t_lo) : (acc_q[c] >= t_hi);
        acc_d[c]          = '0;
      end
      row_d = row_inc(row_q);
      fdp_d = (row_q == RowW'(VBLKS - 1));
    end

    // col_q is already 0 on the evaluate cycle (reset by the row close), so a
    // commit landing there goes to column 0 after the clear.
    if (close) begin
      acc_d[col_q] = sat_add(acc_d[col_q], seg_q);
      col_d        = v_q[1] ? '0 : col_inc(col_q);
    end
  end

  always_comb begin
    pop = '0;
    for (int r = 0; r < VBLKS; r++) begin
      for (int c = 0; c < HBLKS; c++) begin
        pop = pop + CntW'(store_q[r][c]);
      end
    end
    frame_done_d = fdp_q;
    cnt_d        = fdp_q ? pop : cnt_q;
  end

  // Read side follows the undelayed strobes
  always_comb begin
    rcol_d = rcol_q;
    rrow_d = rrow_q;
    if (v_save_i) begin
      rcol_d = '0;
      rrow_d = row_inc(rrow_q);
    end else if (h_save_i) begin
      rcol_d = col_inc(rcol_q);
    end
    rx_d = en_i & store_q[rrow_q][rcol_q];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      y_q   <= '0;
      de_q  <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
      seg_q <= '0;
      for (int c = 0; c < HBLKS; c++) acc_q[c] <= '0;
      for (int r = 0; r < VBLKS; r++) store_q[r] <= '0;
      col_q        <= '0;
      row_q        <= '0;
      eval_q       <= 1'b0;
      fdp_q        <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
      rcol_q       <= '0;
      rrow_q       <= '0;
      rx_q         <= 1'b0;
    end else begin
      y_q          <= y_d;
      de_q         <= de_i;
      h_q          <= {h_q[0], h_save_i};
      v_q          <= {v_q[0], v_save_i};
      seg_q        <= seg_d;
      acc_q        <= acc_d;
      store_q      <= store_d;
      col_q        <= col_d;
      row_q        <= row_d;
      eval_q       <= eval_d;
      fdp_q        <= fdp_d;
      frame_done_q <= frame_done_d;
      cnt_q        <= cnt_d;
      rcol_q       <= rcol_d;
      rrow_q       <= rrow_d;
      rx_q         <= rx_d;
    end
  end

  assign rx_o         = rx_q;
  assign frame_done_o = frame_done_q;
  assign bright_cnt_o = cnt_q;

endmodule

// File: tb/tb_blk_lum_grid.sv
// Directed bench for blk_lum_grid with 2x2-pixel blocks (PXS=4) on the default 10x10 grid.
// Each block is a uniform grey, so a block is bright exactly when its grey level reaches
// the (clamped) threshold selected by its previous decision.
module tb_blk_lum_grid;

  localparam int HB = 10;
  localparam int VB = 10;

  logic        clk = 1'b0;
  logic        rst, de, hs, vs, en;
  logic [23:0] wd;
  logic [7:0]  thres, hyst;
  logic        rx, fd;
  logic [6:0]  cnt;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  logic [7:0] val    [VB][HB];
  bit         exp_rx [VB][HB];
  bit         en_off;

  always #5 clk = ~clk;

  always @(negedge clk) if (fd === 1'b1) fd_cnt++;

  blk_lum_grid #(
    .HBLKS(HB),
    .VBLKS(VB),
    .PXS  (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .de_i        (de),
    .h_save_i    (hs),
    .v_save_i    (vs),
    .wd_i        (wd),
    .thres_i     (thres),
    .hyst_i      (hyst),
    .en_i        (en),
    .rx_o        (rx),
    .frame_done_o(fd),
    .bright_cnt_o(cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit cls(input int g, input bit prev, input int t, input int h);
    int hi, lo;
    hi = (t + h > 255) ? 255 : t + h;
    lo = (t - h < 0) ? 0 : t - h;
    return prev ? (g >= lo) : (g >= hi);
  endfunction

  task automatic px(input logic [7:0] g, input logic d, input logic h, input logic v);
    wd = {g, g, g};
    de = d;
    hs = h;
    vs = v;
    @(posedge clk);
    #1;
    de = 1'b0;
    hs = 1'b0;
    vs = 1'b0;
  endtask

  // Two lines of 10 two-pixel segments; rx checked on the second pixel of each block.
  task automatic normal_row(input int r, input bit chk, input bit en_test);
    for (int line = 0; line < 2; line++) begin
      for (int x = 0; x < 2 * HB; x++) begin
        if (en_test && line == 0 && x == 6) begin
          en     = 1'b0;
          en_off = 1'b1;
        end
        if (chk && line == 0 && (x % 2) == 1)
          check($sformatf("rx r%0d c%0d", r, x / 2), rx, en_off ? 1'b0 : exp_rx[r][x / 2]);
        px(val[r][x / 2], 1'b1, (x % 2) == 1, line == 1 && x == 2 * HB - 1);
      end
    end
  endtask

  // Line 0: 12 segments (last two wrap to cols 0,1); line 1: 8 segments (cols 2..9).
  // Every segment is preceded by two de=0 cycles carrying white.
  task automatic special_row();
    for (int s = 0; s < 12; s++) begin
      px(8'd255, 1'b0, 1'b0, 1'b0);
      px(8'd255, 1'b0, 1'b0, 1'b0);
      px((s >= 10) ? 8'd255 : 8'd0, 1'b1, 1'b0, 1'b0);
      px((s >= 10) ? 8'd255 : 8'd0, 1'b1, 1'b1, 1'b0);
    end
    for (int s = 0; s < 8; s++) begin
      px(8'd255, 1'b0, 1'b0, 1'b0);
      px(8'd255, 1'b0, 1'b0, 1'b0);
      px(8'd0, 1'b1, 1'b0, 1'b0);
      px(8'd0, 1'b1, 1'b1, s == 7);
    end
  endtask

  task automatic run_frame(input string name, input bit special, input int en_row,
                           input int exp_cnt);
    int fd0;
    fd0 = fd_cnt;
    for (int r = 0; r < VB; r++) begin
      if (special && r == 0) special_row();
      else normal_row(r, 1'b1, r == en_row);
    end
    repeat (6) px(8'd0, 1'b0, 1'b0, 1'b0);
    check({name, " frame_done pulses"}, fd_cnt - fd0, 1);
    check({name, " bright_cnt"}, cnt, exp_cnt);
    for (int r = 0; r < VB; r++)
      for (int c = 0; c < HB; c++)
        exp_rx[r][c] = cls(val[r][c], exp_rx[r][c], thres, hyst);
    en     = 1'b1;
    en_off = 1'b0;
  endtask

  task automatic fill(input logic [7:0] g);
    for (int r = 0; r < VB; r++)
      for (int c = 0; c < HB; c++)
        val[r][c] = g;
  endtask

  initial begin
    rst = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0; en = 1'b1; wd = '0;
    thres = 8'd100; hyst = 8'd0; en_off = 1'b0;
    for (int r = 0; r < VB; r++)
      for (int c = 0; c < HB; c++)
        exp_rx[r][c] = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset rx", rx, 0);
    check("reset frame_done", fd, 0);
    check("reset bright_cnt", cnt, 0);

    // Partial white frame, then reset mid-row: must be discarded
    fill(8'd255);
    for (int r = 0; r < 3; r++) normal_row(r, 1'b0, 1'b0);
    for (int x = 0; x < 9; x++) px(8'd255, 1'b1, (x % 2) == 1, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid reset rx", rx, 0);
    check("mid reset frame_done", fd, 0);
    check("mid reset bright_cnt", cnt, 0);
    check("no frame_done before reset", fd_cnt, 0);

    // F1: uniform grey 128, rx all 0 (store cleared by reset)
    fill(8'd128);
    run_frame("grey128", 1'b0, -1, 100);

    // F2: hysteresis; row 0 at 105 keeps 1, row 1 at 80 falls below 90
    thres = 8'd100; hyst = 8'd10;
    for (int c = 0; c < HB; c++) begin
      val[0][c] = 8'd105;
      val[1][c] = 8'd80;
    end
    run_frame("hyst_a", 1'b0, -1, 90);

    // F3: row 1 prev=0: 105 stays 0 (cols 0-4), 111 becomes 1 (cols 5-9)
    for (int c = 0; c < HB; c++) val[1][c] = (c < 5) ? 8'd105 : 8'd111;
    run_frame("hyst_b", 1'b0, -1, 95);

    // F4: white with thres 255, hyst 5: T_hi clamps to 255 so prev=0 blocks turn bright
    fill(8'd255);
    thres = 8'd255; hyst = 8'd5;
    run_frame("clamp_hi", 1'b0, -1, 100);

    // F5: black with thres 3, hyst 10: T_lo clamps to 0 so everything stays bright
    fill(8'd0);
    thres = 8'd3; hyst = 8'd10;
    run_frame("clamp_lo", 1'b0, -1, 100);

    // F6: checkerboard
    thres = 8'd100; hyst = 8'd0;
    for (int r = 0; r < VB; r++)
      for (int c = 0; c < HB; c++)
        val[r][c] = (((r + c) % 2) == 0) ? 8'd255 : 8'd0;
    run_frame("checker", 1'b0, -1, 50);

    // F7: rx follows checkerboard; en_i drops in row 5; row 0 has gaps and 12 strobes.
    // Cols 0,1 get the wrapped white segments (bright), gaps add nothing, rest black.
    fill(8'd0);
    run_frame("wrap_gaps", 1'b1, 5, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
